// File: rtl/fifo_reader.sv
// fifo_reader: drains a FIFO in bursts of up to BURST_LEN reads, registers each word two cycles after its read strobe.
// Define FIFO_READER_CHECK_EN to compile in the incrementing-sequence checker (err_count / mismatch).
module fifo_reader #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned START_VALUE = 0
) (
   input  logic                  rd_clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  rd_en,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [15:0]           word_count,
   output logic [7:0]            err_count,
   output logic                  mismatch
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned ERR_W   = 8;
   localparam int unsigned BURST_W = 4;

   localparam logic [BURST_W-1:0]    BURST_LAST = BURST_W'(BURST_LEN - 1);
   localparam logic [DATA_WIDTH-1:0] START_W    = DATA_WIDTH'(START_VALUE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_rd_en;
   logic                  w_burst_done;
   logic [BURST_W-1:0]    r_burst_cnt;
   logic                  r_rd_pend;
   logic                  r_rd_valid;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [CNT_W-1:0]      r_word_count;

   // State register
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (enable && !empty) w_state_nxt = S_READ;
         S_READ:  if (w_burst_done || empty || !enable) w_state_nxt = S_GAP;
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Read strobe is gated by empty in the same cycle so no underflow read is ever issued
   always_comb begin
      w_rd_en      = 1'b0;
      w_burst_done = 1'b0;
      if (r_state == S_READ) begin
         w_rd_en      = !empty;
         w_burst_done = w_rd_en && (r_burst_cnt == BURST_LAST);
      end
   end

   assign rd_en = w_rd_en;

   // READ is only entered from IDLE, so holding the count clear in IDLE clears it on entry
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_burst_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_burst_cnt <= '0;
      end else if (w_rd_en) begin
         r_burst_cnt <= r_burst_cnt + BURST_W'(1);
      end
   end

   // Capture pipeline: strobe -> pending -> data registered with a one-cycle valid
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_pend    <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_word_count <= '0;
      end else begin
         r_rd_pend  <= w_rd_en;
         r_rd_valid <= r_rd_pend;
         if (r_rd_pend) begin
            r_rd_data    <= fifo_data;
            r_word_count <= r_word_count + CNT_W'(1);
         end
      end
   end

   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign word_count = r_word_count;

`ifdef FIFO_READER_CHECK_EN
   logic [DATA_WIDTH-1:0] r_expected;
   logic [ERR_W-1:0]      r_err_count;
   logic                  r_mismatch;

   // Checks the word as it is captured, so flags update together with rd_valid; resyncs on error
   always_ff @(posedge rd_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_expected  <= START_W;
         r_err_count <= '0;
         r_mismatch  <= 1'b0;
      end else if (r_rd_pend) begin
         if (fifo_data != r_expected) begin
            r_mismatch <= 1'b1;
            if (r_err_count != '1) begin
               r_err_count <= r_err_count + ERR_W'(1);
            end
         end
         r_expected <= fifo_data + DATA_WIDTH'(1);
      end
   end

   assign err_count = r_err_count;
   assign mismatch  = r_mismatch;
`else
   logic w_unused_start;

   assign w_unused_start = ^START_W;
   assign err_count      = '0;
   assign mismatch       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader with a behavioural FIFO model and hand-computed strobe patterns.
// Checker expectations follow FIFO_READER_CHECK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fifo_reader;

   localparam int unsigned DW         = 16;
   localparam int          WRAP_WORDS = 65537;
`ifdef FIFO_READER_CHECK_EN
   localparam int unsigned CHK_ON = 1;
`else
   localparam int unsigned CHK_ON = 0;
`endif
   localparam logic [15:0] T4_STREAM [6] = '{16'd0, 16'd1, 16'd2, 16'd7, 16'd8, 16'd5};

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (BURST_LEN = 4) and its FIFO model
   logic          reset_n, enable, empty, rd_en, rd_valid, mismatch;
   logic [DW-1:0] fifo_data = '0;
   logic [DW-1:0] rd_data;
   logic [15:0]   word_count;
   logic [7:0]    err_count;
   logic [DW-1:0] mem [0:63];
   int            wr_ptr;
   int            rd_ptr    = 0;
   int            underflow = 0;
   logic          hold_empty, flush;

   assign empty = hold_empty || (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (rd_en) begin
         if (rd_ptr == wr_ptr) begin
            underflow <= underflow + 1;
         end else begin
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
         end
      end
   end

   fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .START_VALUE(0)) u_dut (
      .rd_clk     (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .empty      (empty),
      .fifo_data  (fifo_data),
      .rd_en      (rd_en),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .word_count (word_count),
      .err_count  (err_count),
      .mismatch   (mismatch)
   );

   // Wrap DUT (BURST_LEN = 15) fed by an incrementing source of WRAP_WORDS words
   logic          reset_w_n, enable_w, empty_w, rd_en_w, rd_valid_w, mismatch_w;
   logic [DW-1:0] fifo_data_w = '0;
   logic [DW-1:0] rd_data_w;
   logic [15:0]   word_count_w;
   logic [7:0]    err_count_w;
   int            wcnt = 0;

   assign empty_w = (wcnt >= WRAP_WORDS);

   always @(posedge clk) begin
      if (rd_en_w) begin
         fifo_data_w <= DW'(wcnt);
         wcnt        <= wcnt + 1;
      end
   end

   fifo_reader #(.DATA_WIDTH(DW), .BURST_LEN(15), .START_VALUE(0)) u_wrap (
      .rd_clk     (clk),
      .reset_n    (reset_w_n),
      .enable     (enable_w),
      .empty      (empty_w),
      .fifo_data  (fifo_data_w),
      .rd_en      (rd_en_w),
      .rd_valid   (rd_valid_w),
      .rd_data    (rd_data_w),
      .word_count (word_count_w),
      .err_count  (err_count_w),
      .mismatch   (mismatch_w)
   );

   // Captured words of the main DUT
   logic [DW-1:0] cap [$];
   always @(negedge clk) begin
      if (rd_valid) cap.push_back(rd_data);
   end

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string t);
      check({t, "_rd_en"},    32'(rd_en),      32'd0);
      check({t, "_rd_valid"}, 32'(rd_valid),   32'd0);
      check({t, "_rd_data"},  32'(rd_data),    32'd0);
      check({t, "_wcount"},   32'(word_count), 32'd0);
      check({t, "_ecount"},   32'(err_count),  32'd0);
      check({t, "_mismatch"}, 32'(mismatch),   32'd0);
   endtask

   task automatic push(input logic [DW-1:0] w);
      mem[wr_ptr[5:0]] = w;
      wr_ptr           = wr_ptr + 1;
   endtask

   task automatic sample(input int n, output logic [31:0] en_pat, output logic [31:0] v_pat);
      en_pat = '0;
      v_pat  = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         en_pat = {en_pat[30:0], rd_en};
         v_pat  = {v_pat[30:0], rd_valid};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [31:0] cap_at(input int idx);
      return (idx < cap.size()) ? 32'(cap[idx]) : 32'hDEAD_BEEF;
   endfunction

   initial begin
      logic [31:0] ep, vp;
      int          base;
      bit          done, seen;

      reset_n    = 1'b0;
      enable     = 1'b0;
      hold_empty = 1'b1;
      flush      = 1'b0;
      wr_ptr     = 0;
      reset_w_n  = 1'b0;
      enable_w   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_idle("t1");

      // Empty FIFO with enable high: nothing happens
      reset_n = 1'b1;
      enable  = 1'b1;
      sample(20, ep, vp);
      check("t2_rd_en_pattern", ep, 32'h0);
      check("t2_valid_pattern", vp, 32'h0);
      chk_idle("t2");
      hold_empty = 1'b0;

      // Ten words 0..9 in bursts of four
      do_reset();
      base = cap.size();
      for (int i = 0; i < 10; i++) push(DW'(i));
      sample(24, ep, vp);
      check("t3_rd_en_pattern", ep, 32'hF3CC00);
      check("t3_valid_pattern", vp, 32'h3CF300);
      check("t3_ncap", 32'(cap.size() - base), 32'd10);
      for (int i = 0; i < 10; i++) check($sformatf("t3_data%0d", i), cap_at(base + i), 32'(i));
      check("t3_wcount",    32'(word_count), 32'd10);
      check("t3_ecount",    32'(err_count),  32'd0);
      check("t3_mismatch",  32'(mismatch),   32'd0);
      check("t3_underflow", 32'(underflow),  32'd0);

      // Stream with two sequence breaks
      do_reset();
      base = cap.size();
      for (int i = 0; i < 6; i++) push(T4_STREAM[i]);
      repeat (16) @(negedge clk);
      check("t4_ncap", 32'(cap.size() - base), 32'd6);
      for (int i = 0; i < 6; i++) check($sformatf("t4_data%0d", i), cap_at(base + i), 32'(T4_STREAM[i]));
      check("t4_wcount",   32'(word_count), 32'd6);
      check("t4_ecount",   32'(err_count),  (CHK_ON != 0) ? 32'd2 : 32'd0);
      check("t4_mismatch", 32'(mismatch),   (CHK_ON != 0) ? 32'd1 : 32'd0);

      // Empty rises after the second read of a burst, then refills
      do_reset();
      base = cap.size();
      push(16'd0);
      push(16'd1);
      sample(6, ep, vp);
      check("t5_rd_en_a", ep, 32'h30);
      check("t5_valid_a", vp, 32'h0C);
      push(16'd2);
      push(16'd3);
      sample(4, ep, vp);
      check("t5_rd_en_b", ep, 32'hC);
      check("t5_valid_b", vp, 32'h3);
      repeat (4) @(negedge clk);
      check("t5_ncap", 32'(cap.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("t5_data%0d", i), cap_at(base + i), 32'(i));
      check("t5_wcount",    32'(word_count), 32'd4);
      check("t5_underflow", 32'(underflow),  32'd0);

      // Reset pulsed mid-burst after two read strobes
      base = cap.size();
      push(16'd4);
      push(16'd5);
      push(16'd6);
      push(16'd7);
      sample(2, ep, vp);
      check("t6_rd_en_pre", ep, 32'h3);
      reset_n = 1'b0;
      #1;
      chk_idle("t6_rst");
      hold_empty = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("t6_ncap", 32'(cap.size() - base), 32'd0);
      chk_idle("t6_post");
      flush = 1'b1;
      @(negedge clk);
      flush      = 1'b0;
      hold_empty = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_underflow", 32'(underflow), 32'd0);

      // word_count and checker wrap past 0xFFFF
      @(negedge clk);
      reset_w_n = 1'b1;
      enable_w  = 1'b1;
      done      = 1'b0;
      seen      = 1'b0;
      for (int c = 0; c < 80000 && !done; c++) begin
         @(negedge clk);
         if (!seen && word_count_w == 16'hFFFF) begin
            seen = 1'b1;
            check("t7_data_at_ffff", 32'(rd_data_w), 32'h0000_FFFE);
         end
         done = (wcnt >= WRAP_WORDS);
      end
      check("t7_drained", 32'(done), 32'd1);
      check("t7_seen_ffff", 32'(seen), 32'd1);
      repeat (4) @(negedge clk);
      check("t7_wcount",   32'(word_count_w), 32'd1);
      check("t7_rd_data",  32'(rd_data_w),    32'd0);
      check("t7_ecount",   32'(err_count_w),  32'd0);
      check("t7_mismatch", 32'(mismatch_w),   32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
